// File: rtl/seating_pkg.sv
// Shared types for the seat-reservation engine: seat states, request ops, response codes, FSM states.
package seating_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        AWAY     = 2'd1,
        OCCUPIED = 2'd2
    } seat_state_e;

    typedef enum logic [1:0] {
        OP_RELEASE = 2'd0,
        OP_AWAY    = 2'd1,
        OP_OCCUPY  = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RSP_OK      = 3'd0,
        RSP_BUSY    = 3'd1,
        RSP_HOLD    = 3'd2,
        RSP_OWNER   = 3'd3,
        RSP_RANGE   = 3'd4,
        RSP_BAN     = 3'd5,
        RSP_ILLEGAL = 3'd6
    } rsp_code_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } fsm_e;

    localparam logic [1:0] CFG_BAN   = 2'd1;
    localparam logic [1:0] CFG_LIMIT = 2'd2;

endpackage

// File: rtl/seat_ban_table.sv
// Ban table for students whose AWAY seat timed out; entries age once per sweep start.
// Instantiated only when STRIKE_BAN_EN is defined.
module seat_ban_table
    import seating_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SID_W  = 32,
    parameter int TIME_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_i,
    input  logic [SID_W-1:0]  ins_sid_i,
    input  logic [TIME_W-1:0] ins_ttl_i,
    input  logic              dec_i,
    input  logic [SID_W-1:0]  look_sid_i,
    output logic              hit_o
);

    typedef struct packed {
        logic              vld;
        logic [SID_W-1:0]  sid;
        logic [TIME_W-1:0] ttl;
    } ban_ent_t;

    ban_ent_t [DEPTH-1:0] tab_q, tab_d;
    logic has_hit, has_free;
    int   hit_idx, free_idx, min_idx, sel;

    always_comb begin
        has_hit  = 1'b0;
        has_free = 1'b0;
        hit_idx  = 0;
        free_idx = 0;
        min_idx  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tab_q[i].vld && tab_q[i].sid == ins_sid_i && !has_hit) begin
                has_hit = 1'b1;
                hit_idx = i;
            end
            if (!tab_q[i].vld && !has_free) begin
                has_free = 1'b1;
                free_idx = i;
            end
            if (tab_q[i].ttl < tab_q[min_idx].ttl) min_idx = i;
        end
        // Reload an existing entry first, then a free slot, else evict the nearest-to-expiry one.
        sel = has_hit ? hit_idx : (has_free ? free_idx : min_idx);

        tab_d = tab_q;
        if (dec_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tab_q[i].vld) begin
                    if (tab_q[i].ttl <= TIME_W'(1)) tab_d[i] = '0;
                    else                           tab_d[i].ttl = tab_q[i].ttl - TIME_W'(1);
                end
            end
        end
        if (ins_i && ins_ttl_i != '0) tab_d[sel] = '{1'b1, ins_sid_i, ins_ttl_i};
    end

    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tab_q[i].vld && tab_q[i].sid == look_sid_i) hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tab_q <= '0;
        else        tab_q <= tab_d;
    end

endmodule

// File: rtl/seat_reservation_ctrl.sv
// Seat-reservation engine: validates occupy/away/release requests, sweeps AWAY seats on each tick.
// Define STRIKE_BAN_EN to ban students whose seat timed out for a configurable number of ticks.
module seat_reservation_ctrl
    import seating_pkg::*;
#(
    parameter int  NUM_SEATS = 32,
    parameter int  SID_W     = 32,
    parameter int  TIME_W    = 11,
    parameter int  LIMIT_RST = 5,
    parameter int  BAN_RST   = 2,
    parameter int  BAN_DEPTH = 8,
    localparam int SEAT_W    = $clog2(NUM_SEATS) + 1,
    localparam int CNT_W     = $clog2(NUM_SEATS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_i,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SID_W-1:0]       req_sid,
    input  logic [SEAT_W-1:0]      req_seat,
    input  logic [1:0]             req_op,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_code,
    output logic [SEAT_W-1:0]      rsp_seat,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [TIME_W-1:0]      cfg_data,
    output logic [2*NUM_SEATS-1:0] seat_state_o,
    output logic [CNT_W-1:0]       free_cnt_o
);

    localparam int               IDX_W    = $clog2(NUM_SEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEATS - 1);

    if (NUM_SEATS < 2 || NUM_SEATS > 256 || BAN_DEPTH < 1 || BAN_RST < 0 || LIMIT_RST < 0) begin : g_param_chk
        $error("seat_reservation_ctrl: parameter out of range");
    end

    fsm_e                             fsm_q, fsm_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             pend_q, pend_d;
    logic [NUM_SEATS-1:0][1:0]        st_q, st_d;
    logic [NUM_SEATS-1:0][SID_W-1:0]  owner_q, owner_d;
    logic [NUM_SEATS-1:0][TIME_W-1:0] timer_q, timer_d;
    logic [TIME_W-1:0]                limit_q, limit_d;
    logic                             rsp_valid_q, rsp_valid_d;
    logic [2:0]                       rsp_code_q, rsp_code_d;
    logic [SEAT_W-1:0]                rsp_seat_q, rsp_seat_d;
    logic [CNT_W-1:0]                 free_q, free_d;

    logic [IDX_W-1:0] sidx;
    logic [1:0]       cur_st;
    logic             in_range, own, held, banned, sweep_start, timeout_hit;

    assign sidx        = req_seat[IDX_W-1:0];
    assign in_range    = req_seat < SEAT_W'(NUM_SEATS);
    assign cur_st      = st_q[sidx];
    assign own         = owner_q[sidx] == req_sid;
    assign sweep_start = (fsm_q == ST_IDLE) && (tick_i || pend_q);
    assign timeout_hit = (fsm_q == ST_SWEEP) && (st_q[idx_q] == AWAY) && (timer_q[idx_q] == '0);
    assign req_ready   = (fsm_q == ST_IDLE) && !(tick_i || pend_q);

    // A student may hold at most one seat, so every live owner is checked in parallel.
    always_comb begin
        held = 1'b0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if (st_q[i] != EMPTY && owner_q[i] == req_sid) held = 1'b1;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        st_d        = st_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        limit_d     = limit_q;
        rsp_valid_d = 1'b0;
        rsp_code_d  = rsp_code_q;
        rsp_seat_d  = rsp_seat_q;

        if (cfg_we && cfg_sel == CFG_LIMIT) limit_d = cfg_data;

        case (fsm_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    fsm_d  = ST_SWEEP;
                    idx_d  = '0;
                    pend_d = 1'b0;
                end else if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_seat_d  = req_seat;
                    rsp_code_d  = RSP_OK;
                    if (!in_range) begin
                        rsp_code_d = RSP_RANGE;
                    end else begin
                        case (req_op)
                            OP_OCCUPY: begin
                                if (cur_st != EMPTY) begin
                                    if (own) st_d[sidx] = OCCUPIED;
                                    else     rsp_code_d = RSP_BUSY;
                                end else if (held) begin
                                    rsp_code_d = RSP_HOLD;
                                end else if (banned) begin
                                    rsp_code_d = RSP_BAN;
                                end else begin
                                    st_d[sidx]    = OCCUPIED;
                                    owner_d[sidx] = req_sid;
                                end
                            end
                            OP_AWAY: begin
                                if (cur_st == OCCUPIED && own) begin
                                    st_d[sidx]    = AWAY;
                                    timer_d[sidx] = limit_q;
                                end else begin
                                    rsp_code_d = RSP_OWNER;
                                end
                            end
                            OP_RELEASE: begin
                                if (cur_st != EMPTY && own) st_d[sidx] = EMPTY;
                                else                        rsp_code_d = RSP_OWNER;
                            end
                            default: rsp_code_d = RSP_ILLEGAL;
                        endcase
                    end
                end
            end
            ST_SWEEP: begin
                if (tick_i) pend_d = 1'b1;
                if (st_q[idx_q] == AWAY) begin
                    if (timeout_hit) st_d[idx_q] = EMPTY;
                    else             timer_d[idx_q] = timer_q[idx_q] - TIME_W'(1);
                end
                if (idx_q == LAST_IDX) fsm_d = ST_IDLE;
                else                   idx_d = idx_q + IDX_W'(1);
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        free_d = '0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if (st_d[i] == EMPTY) free_d = free_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            st_q        <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            limit_q     <= TIME_W'(LIMIT_RST);
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= '0;
            rsp_seat_q  <= '0;
            free_q      <= CNT_W'(NUM_SEATS);
        end else begin
            fsm_q       <= fsm_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            st_q        <= st_d;
            owner_q     <= owner_d;
            timer_q     <= timer_d;
            limit_q     <= limit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            rsp_seat_q  <= rsp_seat_d;
            free_q      <= free_d;
        end
    end

`ifdef STRIKE_BAN_EN
    logic [TIME_W-1:0] ban_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             ban_q <= TIME_W'(BAN_RST);
        else if (cfg_we && cfg_sel == CFG_BAN)  ban_q <= cfg_data;
    end

    seat_ban_table #(
        .DEPTH  (BAN_DEPTH),
        .SID_W  (SID_W),
        .TIME_W (TIME_W)
    ) u_ban (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins_i      (timeout_hit),
        .ins_sid_i  (owner_q[idx_q]),
        .ins_ttl_i  (ban_q),
        .dec_i      (sweep_start),
        .look_sid_i (req_sid),
        .hit_o      (banned)
    );
`else
    assign banned = 1'b0;
`endif

    assign rsp_valid    = rsp_valid_q;
    assign rsp_code     = rsp_code_q;
    assign rsp_seat     = rsp_seat_q;
    assign seat_state_o = st_q;
    assign free_cnt_o   = free_q;

endmodule
